// File: rtl/ula_arbitro.sv
// ula_arbitro: shares one combinational ALU (ULA) between two requesters.
//
// Requester 0 (data path) and requester 1 (address/branch unit) are arbitrated
// round-robin. The winner's sel/x/y are latched into op registers and driven to
// the ALU for one cycle, or for MULDIV_CYCLES cycles for mul (1001) and div (1010).
// The ALU result and flags are then captured, and a one-cycle ack/valid is returned.
//
// Ports:
//   clk, reset             rising-edge clock, async active-high reset
//   req0/req1              requests
//   sel0/sel1              ALU opcodes
//   x0,y0/x1,y1            operands
//   ack0/ack1              one-cycle completion pulse to the granted requester
//   ula_sel/ula_X/ula_Y    ALU drive; quiet (1111/0/0) outside EXEC
//   ula_res/neg/zero       ALU result inputs
//   res/neg/zero/divz      registered result and flags of the last completed op
//   valid                  high in the ack cycle
//   owner                  requester of the current or last op
//   busy                   high in EXEC and DONE
module ula_arbitro #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [3:0]       sel0,
  input  logic [3:0]       sel1,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  output logic             ack0,
  output logic             ack1,
  output logic [3:0]       ula_sel,
  output logic [WIDTH-1:0] ula_X,
  output logic [WIDTH-1:0] ula_Y,
  input  logic [WIDTH-1:0] ula_res,
  input  logic             ula_neg,
  input  logic             ula_zero,
  output logic [WIDTH-1:0] res,
  output logic             neg,
  output logic             zero,
  output logic             divz,
  output logic             valid,
  output logic             owner,
  output logic             busy
);

  localparam int unsigned CountW = $clog2(MULDIV_CYCLES + 1);

  localparam logic [3:0] SelMul  = 4'b1001;
  localparam logic [3:0] SelDiv  = 4'b1010;
  localparam logic [3:0] SelIdle = 4'b1111;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         op_sel_q, op_sel_d;
  logic [WIDTH-1:0]   op_x_q, op_x_d;
  logic [WIDTH-1:0]   op_y_q, op_y_d;
  logic [CountW-1:0]  count_q, count_d;
  logic               owner_q, owner_d;
  logic               last_owner_q, last_owner_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               neg_q, neg_d;
  logic               zero_q, zero_d;
  logic               divz_q, divz_d;

  // Round-robin: on contention the requester that was not served last wins.
  logic       grant_who;
  logic [3:0] grant_sel;
  assign grant_who = (req0 && req1) ? ~last_owner_q : req1;
  assign grant_sel = grant_who ? sel1 : sel0;

  always_comb begin
    state_d      = state_q;
    op_sel_d     = op_sel_q;
    op_x_d       = op_x_q;
    op_y_d       = op_y_q;
    count_d      = count_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    res_d        = res_q;
    neg_d        = neg_q;
    zero_d       = zero_q;
    divz_d       = divz_q;

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          state_d  = StExec;
          owner_d  = grant_who;
          op_sel_d = grant_sel;
          op_x_d   = grant_who ? x1 : x0;
          op_y_d   = grant_who ? y1 : y0;
          count_d  = (grant_sel == SelMul || grant_sel == SelDiv) ?
                     CountW'(MULDIV_CYCLES) : CountW'(1);
        end
      end
      StExec: begin
        count_d = count_q - CountW'(1);
        // <= rather than == so a corrupted zero count cannot stall the FSM
        if (count_q <= CountW'(1)) begin
          state_d = StDone;
          if (op_sel_q == SelDiv && op_y_q == '0) begin
            // Divide by zero: saturate to all ones and flag it.
            res_d  = '1;
            neg_d  = 1'b1;
            zero_d = 1'b0;
            divz_d = 1'b1;
          end else begin
            res_d  = ula_res;
            neg_d  = ula_neg;
            zero_d = ula_zero;
            divz_d = 1'b0;
          end
        end
      end
      StDone: begin
        last_owner_d = owner_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      op_sel_q     <= SelIdle;
      op_x_q       <= '0;
      op_y_q       <= '0;
      count_q      <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      res_q        <= '0;
      neg_q        <= 1'b0;
      zero_q       <= 1'b0;
      divz_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_sel_q     <= op_sel_d;
      op_x_q       <= op_x_d;
      op_y_q       <= op_y_d;
      count_q      <= count_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      res_q        <= res_d;
      neg_q        <= neg_d;
      zero_q       <= zero_d;
      divz_q       <= divz_d;
    end
  end

  // Outputs come only from registers and state decode; no path from req*.
  always_comb begin
    ula_sel = SelIdle;
    ula_X   = '0;
    ula_Y   = '0;
    if (state_q == StExec) begin
      ula_sel = op_sel_q;
      ula_X   = op_x_q;
      ula_Y   = op_y_q;
    end
  end

  assign valid = (state_q == StDone);
  assign ack0  = valid && !owner_q;
  assign ack1  = valid && owner_q;
  assign busy  = (state_q != StIdle);
  assign owner = owner_q;
  assign res   = res_q;
  assign neg   = neg_q;
  assign zero  = zero_q;
  assign divz  = divz_q;

endmodule

// File: tb/tb_ula_arbitro.sv
// tb_ula_arbitro: self-checking bench for ula_arbitro. A behavioural ALU answers
// the DUT's ALU port; expected results are queued when requests are driven and
// compared by a monitor whenever an ack appears.
module tb_ula_arbitro;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned MD    = 4;

  logic             clk;
  logic             reset;
  logic             req0, req1;
  logic [3:0]       sel0, sel1;
  logic [WIDTH-1:0] x0, y0, x1, y1;
  logic             ack0, ack1;
  logic [3:0]       ula_sel;
  logic [WIDTH-1:0] ula_X, ula_Y;
  logic [WIDTH-1:0] ula_res;
  logic             ula_neg, ula_zero;
  logic [WIDTH-1:0] res;
  logic             neg, zero, divz, valid, owner, busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        who;
    logic [31:0] res;
    logic        neg;
    logic        zero;
    logic        divz;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  ula_arbitro #(
    .WIDTH         (WIDTH),
    .MULDIV_CYCLES (MD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .req1     (req1),
    .sel0     (sel0),
    .sel1     (sel1),
    .x0       (x0),
    .y0       (y0),
    .x1       (x1),
    .y1       (y1),
    .ack0     (ack0),
    .ack1     (ack1),
    .ula_sel  (ula_sel),
    .ula_X    (ula_X),
    .ula_Y    (ula_Y),
    .ula_res  (ula_res),
    .ula_neg  (ula_neg),
    .ula_zero (ula_zero),
    .res      (res),
    .neg      (neg),
    .zero     (zero),
    .divz     (divz),
    .valid    (valid),
    .owner    (owner),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; division by zero returns 0 so the DUT override is visible.
  always_comb begin
    ula_res = '0;
    case (ula_sel)
      4'b0000: ula_res = ula_X + ula_Y;
      4'b0001: ula_res = ula_X - ula_Y;
      4'b0010: ula_res = ula_X & ula_Y;
      4'b0011: ula_res = ula_X | ula_Y;
      4'b0100: ula_res = ula_X ^ ula_Y;
      4'b0101: ula_res = ula_X << ula_Y[4:0];
      4'b0110: ula_res = ula_X >> ula_Y[4:0];
      4'b0111: ula_res = ~ula_X;
      4'b1000: ula_res = $signed(ula_X) >>> ula_Y[4:0];
      4'b1001: ula_res = ula_X * ula_Y;
      4'b1010: ula_res = (ula_Y == '0) ? '0 : ula_X / ula_Y;
      default: ula_res = '0;
    endcase
    ula_zero = (ula_res == '0);
    ula_neg  = ula_res[WIDTH-1];
  end

  // Scoreboard monitor: every ack/valid cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && (ack0 || ack1 || valid)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_ack: ack0=%0b ack1=%0b valid=%0b, required no completion",
                 ack0, ack1, valid);
      end else begin
        mon_e = exp_q.pop_front();
        if ({ack0, ack1, valid, owner, res, neg, zero, divz} !==
            {!mon_e.who, mon_e.who, 1'b1, mon_e.who, mon_e.res, mon_e.neg, mon_e.zero,
             mon_e.divz}) begin
          errors++;
          $display({"FAIL sb_result: ack0=%0b ack1=%0b valid=%0b owner=%0b res=%h neg=%0b ",
                    "zero=%0b divz=%0b, required owner=%0b res=%h neg=%0b zero=%0b divz=%0b"},
                   ack0, ack1, valid, owner, res, neg, zero, divz,
                   mon_e.who, mon_e.res, mon_e.neg, mon_e.zero, mon_e.divz);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---- stimulus helpers (no comparisons inside) ----

  task automatic push_exp(input logic who, input logic [31:0] r, input logic n, z, d);
    exp_t e;
    e.who  = who;
    e.res  = r;
    e.neg  = n;
    e.zero = z;
    e.divz = d;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic who, input logic [3:0] s, input logic [31:0] x, y,
                       input logic [31:0] r, input logic n, z, d);
    if (who) begin
      sel1 = s; x1 = x; y1 = y; req1 = 1'b1;
    end else begin
      sel0 = s; x0 = x; y0 = y; req0 = 1'b1;
    end
    push_exp(who, r, n, z, d);
  endtask

  // Counts edges until an ack is seen at a negedge; -1 if none within the bound.
  task automatic wait_ack(output int n);
    int i;
    n = -1;
    i = 0;
    while (n < 0 && i < 20) begin
      @(posedge clk);
      @(negedge clk);
      i++;
      if (ack0 || ack1) n = i;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---- scenarios ----

  task automatic test_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    sel0 = '0; sel1 = '0; x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    #1;
    checks++;
    if ({ack0, ack1, valid, busy, owner, res, neg, zero, divz, ula_sel, ula_X, ula_Y} !==
        {5'b0, 32'h0, 3'b0, 4'hF, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_state: busy=%0b owner=%0b res=%h ula_sel=%b ula_X=%h, required 0 0 0 1111 0",
               busy, owner, res, ula_sel, ula_X);
    end
    req0 = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ack0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: busy=%0b ack0=%0b, required 0 0", busy, ack0);
    end
    do_reset();
  endtask

  task automatic test_simple_add();
    int n;
    do_reset();
    issue(1'b0, 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0);
    wait_ack(n);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL add_latency: edges=%0d, required 2", n);
    end
    checks++;
    if (ack1 !== 1'b0 || owner !== 1'b0) begin
      errors++;
      $display("FAIL add_owner: ack1=%0b owner=%0b, required 0 0", ack1, owner);
    end
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({ack0, valid, busy, res, ula_sel} !== {3'b0, 32'd12, 4'hF}) begin
      errors++;
      $display("FAIL add_after: ack0=%0b valid=%0b busy=%0b res=%h ula_sel=%b, required 0 0 0 c 1111",
               ack0, valid, busy, res, ula_sel);
    end
  endtask

  task automatic test_contention();
    int n;
    do_reset();
    sel0 = 4'b0001; x0 = 32'd3;    y0 = 32'd5;  req0 = 1'b1;
    sel1 = 4'b0010; x1 = 32'hF0;   y1 = 32'h3C; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_exp(1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
      else            push_exp(1'b1, 32'h0000_0030, 1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      wait_ack(n);
      checks++;
      if (n !== ((k == 0) ? 2 : 3)) begin
        errors++;
        $display("FAIL rr_spacing: op=%0d edges=%0d, required %0d", k, n, (k == 0) ? 2 : 3);
      end
      checks++;
      if (owner !== k[0]) begin
        errors++;
        $display("FAIL rr_order: op=%0d owner=%0b, required %0b", k, owner, k[0]);
      end
      if (k == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
  endtask

  task automatic test_muldiv();
    int n;
    do_reset();
    issue(1'b1, 4'b1001, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    for (int i = 0; i < int'(MD); i++) begin
      @(negedge clk);
      if (i == 0) begin
        x1 = 32'd100;
        y1 = 32'd9;
      end
      checks++;
      if ({busy, ack1, ula_sel, ula_X, ula_Y} !== {1'b1, 1'b0, 4'b1001, 32'd6, 32'd7}) begin
        errors++;
        $display("FAIL mul_hold: cycle=%0d busy=%0b ack1=%0b ula_sel=%b X=%h Y=%h, required 1 0 1001 6 7",
                 i, busy, ack1, ula_sel, ula_X, ula_Y);
      end
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ack1 !== 1'b1) begin
      errors++;
      $display("FAIL mul_ack: ack1=%0b, required 1", ack1);
    end
    req1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, ula_sel, ula_X, ula_Y} !== {1'b0, 4'hF, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL mul_quiet: busy=%0b ula_sel=%b X=%h Y=%h, required 0 1111 0 0",
               busy, ula_sel, ula_X, ula_Y);
    end
    // div by zero followed by a normal divide
    issue(1'b0, 4'b1010, 32'd10, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    wait_ack(n);
    checks++;
    if (n !== int'(MD) + 1) begin
      errors++;
      $display("FAIL divz_latency: edges=%0d, required %0d", n, MD + 1);
    end
    req0 = 1'b0;
    @(negedge clk);
    issue(1'b0, 4'b1010, 32'd10, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0);
    wait_ack(n);
    checks++;
    if (n !== int'(MD) + 1) begin
      errors++;
      $display("FAIL div_latency: edges=%0d, required %0d", n, MD + 1);
    end
    req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int n;
    logic seen;
    do_reset();
    issue(1'b0, 4'b0000, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
    wait_ack(n);
    req0 = 1'b0;
    @(negedge clk);
    issue(1'b1, 4'b1001, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    req1  = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({ack0, ack1, valid, busy, owner, res, neg, zero, divz, ula_sel, ula_X, ula_Y} !==
        {5'b0, 32'h0, 3'b0, 4'hF, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL abort_reset: busy=%0b owner=%0b res=%h ula_sel=%b, required 0 0 0 1111",
               busy, owner, res, ula_sel);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack0 || ack1 || valid || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_ack: activity=%0b, required 0", seen);
    end
    sel0 = 4'b0000; x0 = 32'd1; y0 = 32'd1; req0 = 1'b1;
    sel1 = 4'b0000; x1 = 32'd2; y1 = 32'd2; req1 = 1'b1;
    push_exp(1'b0, 32'd2, 1'b0, 1'b0, 1'b0);
    push_exp(1'b1, 32'd4, 1'b0, 1'b0, 1'b0);
    wait_ack(n);
    checks++;
    if (n !== 2 || owner !== 1'b0) begin
      errors++;
      $display("FAIL abort_first_grant: edges=%0d owner=%0b, required 2 0", n, owner);
    end
    req0 = 1'b0;
    wait_ack(n);
    checks++;
    if (n !== 3 || owner !== 1'b1) begin
      errors++;
      $display("FAIL abort_second_grant: edges=%0d owner=%0b, required 3 1", n, owner);
    end
    req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_ops();
    int n;
    do_reset();
    issue(1'b0, 4'b0111, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    wait_ack(n);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL not_latency: edges=%0d, required 2", n);
    end
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, ula_sel, ula_X, ula_Y} !== {1'b0, 4'hF, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL not_quiet: busy=%0b ula_sel=%b X=%h Y=%h, required 0 1111 0 0",
               busy, ula_sel, ula_X, ula_Y);
    end
    issue(1'b1, 4'b1100, 32'd123, 32'd456, 32'd0, 1'b0, 1'b1, 1'b0);
    wait_ack(n);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL sel1100_latency: edges=%0d, required 2", n);
    end
    req1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, ula_sel, ula_X, ula_Y, zero} !== {1'b0, 4'hF, 32'h0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL sel1100_quiet: busy=%0b ula_sel=%b X=%h Y=%h zero=%0b, required 0 1111 0 0 1",
               busy, ula_sel, ula_X, ula_Y, zero);
    end
  endtask

  initial begin
    test_reset();
    test_simple_add();
    test_contention();
    test_muldiv();
    test_reset_abort();
    test_zero_ops();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL sb_drain: pending=%0d, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_arbitro.md
# ula_arbitro

Sequencing controller that shares the single combinational ALU (`ULA`) between two requesters: data path (port 0) and address/branch unit (port 1). It arbitrates round-robin and drives the ALU from registered operands. It holds multiply/divide operands stable for a configurable number of cycles, then captures result and flags into registers. A one-cycle acknowledge returns them to the winning requester.

## Interface
- `WIDTH`, 32, operand/result width (ALU is 32-bit; only 32 is supported)
- `MULDIV_CYCLES`, 4, cycles ALU inputs are held for `sel` 4'b1001 / 4'b1010 (≥1)
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `req0` / `req1`  in  1  request from requester 0 / 1
- `sel0` / `sel1`  in  4  ALU operation code (ULA encoding)
- `x0`, `y0` / `x1`, `y1`  in  WIDTH  operands
- `ack0` / `ack1`  out  1  one-cycle completion pulse to requester
- `ula_sel`  out  4  to ALU `sel`
- `ula_X`, `ula_Y`  out  WIDTH  to ALU operands
- `ula_res`  in  WIDTH  from ALU; `ula_neg`, `ula_zero`  in  1  from ALU
- `res`  out  WIDTH  registered result
- `neg`, `zero`, `divz`  out  1  registered flags; `divz` = divide by zero
- `valid`  out  1  high in the cycle `res` belongs to the acked op
- `owner`  out  1  requester of current/last op
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: if any `reqN` is high at the clock edge, latch the winner's sel/x/y into op registers. Set `owner`, load `count` = MULDIV_CYCLES for sel 1001/1010, else 1. Go to EXEC. With no request, stay.
- Arbitration: one requester → it wins. Both → the one ≠ `last_owner` wins. `last_owner` resets to 1, so 0 wins the first contention.
- EXEC: `ula_sel/X/Y` = op registers; `count` decrements each edge. At the edge where `count`==1, capture and go to DONE:
  - `res`/`neg`/`zero` ← `ula_res`/`ula_neg`/`ula_zero`, `divz` ← 0;
  - exception: op sel 1010 with Y==0 → `res`=32'hFFFFFFFF, `neg`=1, `zero`=0, `divz`=1.
- DONE: `ack[owner]`=1, `valid`=1 for exactly this cycle. `last_owner` ← `owner`. Go to IDLE.
- Outside EXEC, ALU is quieted: `ula_sel`=4'b1111, `ula_X`=`ula_Y`=0.
- `res`, `neg`, `zero`, `divz` hold until the next capture. `owner` holds until the next grant.
- sel 1011–1111: single-cycle; result is whatever the ALU returns (0, `zero`=1).
- Requester must keep `reqN` and operands valid until sampled in IDLE. Operands are latched, so later changes do not affect the op.
- If `reqN` is still high in the IDLE cycle after its ack, it is a new request. Requesters drop `req` on seeing `ack`.
- `reqN` dropped after grant: op completes and ack still pulses.

## Timing
- Reset (async, immediate): state=IDLE; `ack0`=`ack1`=`valid`=0; `res`=0; `neg`=`zero`=`divz`=0; `owner`=0; `last_owner`=1; `count`=0; `busy`=0; ALU ports quiet.
- Reset mid-EXEC/DONE aborts the op; no ack is ever issued for it.
- Latency, request sampled at edge E0:
  - simple op: EXEC during E0–E1; ack/valid during E1–E2;
  - mul/div: ack/valid during E(MULDIV_CYCLES)–E(MULDIV_CYCLES+1).
- Throughput: IDLE→EXEC→DONE→IDLE gives 3 cycles per simple op and MULDIV_CYCLES+2 per mul/div.
- `busy` is high in EXEC and DONE.
- All outputs are registered or decoded from state only. There are no combinational paths from `reqN` to any output.

## Test plan
- Reset then `req0`, sel=0000, x0=5, y0=7 → ack0 one cycle, 2 edges after grant, `res`=12, neg=0, zero=0, owner=0, ack1 never high.
- Both requesters held high: req0 sub 3−5, req1 and 0xF0&0x3C. Grant order 0,1,0,1. Op 0 gives res=0xFFFFFFFE, neg=1; op 1 gives res=0x30. Grants are 3 cycles apart.
- MULDIV_CYCLES=4, `req1` mul 6×7 → `ula_sel`=1001 stable 4 cycles; ack1 5 edges after grant; res=42. Operands changed after grant do not alter the result.
- `req0` div 10/0 → res=0xFFFFFFFF, divz=1, neg=1, zero=0. A following 10/3 gives res=3, divz=0.
- Reset asserted mid-EXEC of a mul → outputs are immediately at reset values and no ack follows. After reset, simultaneous requests grant requester 0 first.
- sel=0111 with x=0xFFFFFFFF → res=0, zero=1. sel=1100 → res=0, zero=1. ALU inputs return to sel=1111, X=Y=0 after EXEC.
